// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map, bit positions and bus response codes for the timer
package timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_LOAD   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_LOAD   = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_STOP_BIT   = 1;
    localparam int CTRL_IE_BIT     = 2;
    localparam int STATUS_PEND_BIT = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Merge a write into an existing word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_axil_regs_if.sv
// rtl/timer_axil_regs_if.sv - AXI4-Lite register bus between interconnect and the timer register block
interface timer_axil_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/timer_axil_regs.sv
// rtl/timer_axil_regs.sv - AXI4-Lite register block for the 32-bit timer core
// Turns bus writes into start/stop pulses and a reload value; exposes count and a maskable W1C interrupt.
module timer_axil_regs
    import timer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    timer_axil_regs_if.slave  s,
    output logic              tmr_start,
    output logic              tmr_stop,
    output logic [DATA_W-1:0] tmr_load_val,
    input  logic [DATA_W-1:0] tmr_count,
    input  logic              tmr_irq,
    output logic              irq
);

    logic                ready_en;
    logic                aw_held;
    reg_sel_e            aw_sel;
    logic                w_held;
    logic [DATA_W-1:0]   w_data;
    logic [3:0]          w_strb;
    logic                bvalid_q;

    logic                ar_pend;
    reg_sel_e            ar_sel;
    logic [DATA_W-1:0]   count_snap;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   rd_mux;

    logic [DATA_W-1:0]   load_q;
    logic                ie_q;
    logic                pend_q;
    logic                tmr_irq_prev;
    logic                start_q;
    logic                stop_q;
    logic                irq_q;

    logic [ADDR_W-1:0]   awaddr_in;
    logic [ADDR_W-1:0]   araddr_in;
    logic                unused_addr_bits;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                commit;
    logic                ctrl_wr;
    logic                status_wr;
    logic                pend_clr;
    logic                irq_rise;

    assign awaddr_in        = s.awaddr;
    assign araddr_in        = s.araddr;
    assign unused_addr_bits = ^{awaddr_in, araddr_in};

    // Readies stay low until the first edge after reset has been released.
    assign s.awready = ready_en && !aw_held && !bvalid_q;
    assign s.wready  = ready_en && !w_held  && !bvalid_q;
    assign s.arready = ready_en && !rvalid_q && !ar_pend;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = RESP_OKAY;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = RESP_OKAY;

    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid  && s.wready;
    assign ar_hs = s.arvalid && s.arready;

    assign commit    = aw_held && w_held;
    assign ctrl_wr   = commit && (aw_sel == REG_CTRL)   && w_strb[0];
    assign status_wr = commit && (aw_sel == REG_STATUS) && w_strb[0];
    assign pend_clr  = status_wr && w_data[STATUS_PEND_BIT];
    assign irq_rise  = tmr_irq && !tmr_irq_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write path: AW and W are captured independently and retired together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held  <= 1'b0;
            aw_sel   <= REG_CTRL;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_sel  <= reg_sel_e'(awaddr_in[3:2]);
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
            end else if (bvalid_q && s.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_q       <= '0;
            ie_q         <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            pend_q       <= 1'b0;
            tmr_irq_prev <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            tmr_irq_prev <= tmr_irq;
            if (commit && aw_sel == REG_LOAD) begin
                load_q <= apply_strb(load_q, w_data, w_strb);
            end
            if (ctrl_wr) begin
                start_q <= w_data[CTRL_START_BIT];
                stop_q  <= w_data[CTRL_STOP_BIT];
                ie_q    <= w_data[CTRL_IE_BIT];
            end
            // A new rising edge wins over a coincident W1C so no event is lost.
            pend_q <= (pend_q && !pend_clr) || irq_rise;
            irq_q  <= pend_q && ie_q;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (ar_sel)
            REG_CTRL:   rd_mux[CTRL_IE_BIT]     = ie_q;
            REG_LOAD:   rd_mux                  = load_q;
            REG_COUNT:  rd_mux                  = count_snap;
            REG_STATUS: rd_mux[STATUS_PEND_BIT] = pend_q;
            default:    rd_mux                  = '0;
        endcase
    end

    // Read path: count is snapshotted at the AR handshake, data returned the edge after.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_pend    <= 1'b0;
            ar_sel     <= REG_CTRL;
            count_snap <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (ar_hs) begin
                ar_pend    <= 1'b1;
                ar_sel     <= reg_sel_e'(araddr_in[3:2]);
                count_snap <= tmr_count;
            end
            if (ar_pend) begin
                ar_pend  <= 1'b0;
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && s.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign tmr_start    = start_q;
    assign tmr_stop     = stop_q;
    assign tmr_load_val = load_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_timer_axil_regs.sv
// tb/tb_timer_axil_regs.sv - directed self-checking bench for timer_axil_regs
module tb_timer_axil_regs;
    import timer_pkg::*;

    logic        clk;
    logic        rstn;
    logic        tmr_start;
    logic        tmr_stop;
    logic [31:0] tmr_load_val;
    logic [31:0] tmr_count;
    logic        tmr_irq;
    logic        irq;
    logic        ramp;

    int n_checks;
    int n_pass;

    logic        st1, sp1, st2, sp2;
    logic [31:0] rd;

    timer_axil_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    timer_axil_regs #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .s            (bus),
        .tmr_start    (tmr_start),
        .tmr_stop     (tmr_stop),
        .tmr_load_val (tmr_load_val),
        .tmr_count    (tmr_count),
        .tmr_irq      (tmr_irq),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ramp) tmr_count = tmr_count + 32'd1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic s1, output logic p1, output logic s2, output logic p2);
        int cnt;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        cnt = 0;
        while (!bus.bvalid && cnt < 8) begin
            step();
            cnt++;
        end
        check("b_latency", cnt, 1);
        check("bresp", bus.bresp, RESP_OKAY);
        s1 = tmr_start;
        p1 = tmr_stop;
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        s2 = tmr_start;
        p2 = tmr_stop;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int cnt;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        cnt = 0;
        while (!bus.rvalid && cnt < 8) begin
            step();
            cnt++;
        end
        check("r_latency", cnt, 1);
        check("rresp", bus.rresp, RESP_OKAY);
        data = bus.rdata;
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        ramp     = 1'b0;
        rstn     = 1'b0;
        tmr_count = '0;
        tmr_irq  = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        step();
        step();
        check("rst_awready", bus.awready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_load", tmr_load_val, 0);
        check("rst_irq", irq, 0);
        rstn = 1'b1;
        step();
        check("post_awready", bus.awready, 1);
        check("post_wready", bus.wready, 1);
        check("post_arready", bus.arready, 1);

        // LOAD full write, AW and W together
        axi_write(OFF_LOAD, 32'hDEAD_BEEF, 4'hF, st1, sp1, st2, sp2);
        check("load_full", tmr_load_val, 32'hDEAD_BEEF);
        check("load_no_start", st1, 0);
        axi_read(OFF_LOAD, rd);
        check("load_readback", rd, 32'hDEAD_BEEF);

        // W ahead of AW with one byte lane, B held under bready=0
        axi_write(OFF_LOAD, 32'h0, 4'hF, st1, sp1, st2, sp2);
        check("load_zero", tmr_load_val, 0);
        bus.wdata  = 32'h0000_5A00;
        bus.wstrb  = 4'h2;
        bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        check("w_held_wready", bus.wready, 0);
        check("w_held_awready", bus.awready, 1);
        step();
        step();
        check("w_only_nobvalid", bus.bvalid, 0);
        check("w_only_load", tmr_load_val, 0);
        bus.awaddr  = OFF_LOAD;
        bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        check("late_aw_bvalid0", bus.bvalid, 0);
        step();
        check("late_aw_bvalid1", bus.bvalid, 1);
        check("strb_load", tmr_load_val, 32'h0000_5A00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bvalid_hold", bus.bvalid, 1);
            check("bhold_awready", bus.awready, 0);
        end
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("bvalid_drop", bus.bvalid, 0);
        check("after_b_awready", bus.awready, 1);

        // CTRL: start pulse + IE, then start and stop together
        axi_write(OFF_CTRL, 32'h5, 4'hF, st1, sp1, st2, sp2);
        check("ctrl5_start", st1, 1);
        check("ctrl5_stop", sp1, 0);
        check("ctrl5_start_end", st2, 0);
        axi_read(OFF_CTRL, rd);
        check("ctrl_read_ie", rd, 32'h4);
        axi_write(OFF_CTRL, 32'h3, 4'hF, st1, sp1, st2, sp2);
        check("ctrl3_start", st1, 1);
        check("ctrl3_stop", sp1, 1);
        check("ctrl3_start_end", st2, 0);
        check("ctrl3_stop_end", sp2, 0);
        axi_read(OFF_CTRL, rd);
        check("ctrl_read_ie0", rd, 32'h0);

        // Interrupt: rise, W1C, and W1C racing a new rise
        axi_write(OFF_CTRL, 32'h4, 4'hF, st1, sp1, st2, sp2);
        check("ctrl4_no_start", st1, 0);
        tmr_irq = 1'b1;
        step();
        check("irq_n1", irq, 0);
        step();
        check("irq_n2", irq, 1);
        axi_read(OFF_STATUS, rd);
        check("status_pend", rd, 32'h1);
        axi_write(OFF_STATUS, 32'h1, 4'h1, st1, sp1, st2, sp2);
        check("w1c_irq", irq, 0);
        axi_read(OFF_STATUS, rd);
        check("w1c_status", rd, 32'h0);
        tmr_irq = 1'b0;
        step();
        step();
        bus.awaddr  = OFF_STATUS;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h1;
        bus.wstrb   = 4'h1;
        bus.wvalid  = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        tmr_irq = 1'b1;
        step();
        check("race_bvalid", bus.bvalid, 1);
        bus.bready = 1'b1;
        step();
        bus.bready = 1'b0;
        check("race_irq", irq, 1);
        axi_read(OFF_STATUS, rd);
        check("race_status", rd, 32'h1);

        // COUNT snapshot while the core keeps counting
        tmr_count = 32'h0000_1000;
        ramp = 1'b1;
        bus.araddr  = OFF_COUNT;
        bus.arvalid = 1'b1;
        step();
        bus.arvalid = 1'b0;
        check("count_rvalid0", bus.rvalid, 0);
        step();
        check("count_rvalid1", bus.rvalid, 1);
        check("count_snap", bus.rdata, 32'h0000_1000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("count_hold_valid", bus.rvalid, 1);
            check("count_hold_data", bus.rdata, 32'h0000_1000);
        end
        bus.rready = 1'b1;
        step();
        bus.rready = 1'b0;
        ramp = 1'b0;
        check("count_rvalid_drop", bus.rvalid, 0);

        // Reset with both responses outstanding
        bus.awaddr = OFF_LOAD; bus.wdata = 32'hCAFE_0000; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = OFF_LOAD; bus.arvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        step();
        check("pre_rst_bvalid", bus.bvalid, 1);
        check("pre_rst_rvalid", bus.rvalid, 1);
        step();
        rstn = 1'b0;
        #1;
        check("mid_rst_bvalid", bus.bvalid, 0);
        check("mid_rst_rvalid", bus.rvalid, 0);
        check("mid_rst_load", tmr_load_val, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_awready", bus.awready, 0);
        check("mid_rst_start", tmr_start, 0);
        tmr_irq = 1'b0;
        step();
        rstn = 1'b1;
        step();
        check("rerst_awready", bus.awready, 1);
        check("rerst_arready", bus.arready, 1);
        axi_write(OFF_LOAD, 32'h1234_5678, 4'hF, st1, sp1, st2, sp2);
        check("rerst_load", tmr_load_val, 32'h1234_5678);
        axi_read(OFF_LOAD, rd);
        check("rerst_load_rd", rd, 32'h1234_5678);
        axi_read(OFF_STATUS, rd);
        check("rerst_status", rd, 32'h0);
        axi_read(OFF_CTRL, rd);
        check("rerst_ctrl", rd, 32'h0);
        tmr_count = 32'hABCD_0123;
        axi_read(OFF_COUNT, rd);
        check("rerst_count", rd, 32'hABCD_0123);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_axil_regs.md
# timer_axil_regs

AXI4-Lite responder that exposes the 32-bit timer core as a four-register memory-mapped peripheral. Decodes bus writes into single-cycle start/stop pulses and a held reload value, returns live count and interrupt status on reads, and turns the core's sticky irq level into a maskable, write-1-to-clear interrupt. Sits between the system interconnect and the timer core inside the timer top level.

## Interface
- ADDR_W, 4: byte-address width; offsets decoded from addr[3:2], addr[1:0] ignored.
- DATA_W, 32: data width; fixed, other values unsupported.
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- s_awaddr / s_awvalid / s_awready  in/in/out  ADDR_W/1/1  write address channel
- s_wdata / s_wstrb / s_wvalid / s_wready  in/in/in/out  32/4/1/1  write data channel
- s_bresp / s_bvalid / s_bready  out/out/in  2/1/1  write response
- s_araddr / s_arvalid / s_arready  in/in/out  ADDR_W/1/1  read address channel
- s_rdata / s_rresp / s_rvalid / s_rready  out/out/out/in  32/2/1/1  read data channel
- tmr_start  out  1  one-cycle start pulse to core
- tmr_stop  out  1  one-cycle stop pulse to core
- tmr_load_val  out  32  reload value to core
- tmr_count  in  32  core cur_count
- tmr_irq  in  1  core irq level
- irq  out  1  interrupt to system

## Operation
- Register map: 0x0 CTRL: bit0 START (W1, reads 0), bit1 STOP (W1, reads 0), bit2 IE (RW). 0x4 LOAD: RW, byte strobes honoured. 0x8 COUNT: RO, writes ignored. 0xC STATUS: bit0 PEND (W1C), other bits read 0.
- CTRL/STATUS writes take effect only when wstrb[0]=1.
- PEND set on rising edge of tmr_irq (registered previous value). Set beats simultaneous W1C clear.
- irq = PEND & IE, registered output.
- START and STOP written together: both pulses asserted same cycle; core resolves priority (stop wins).
- bresp and rresp always OKAY (2'b00); all four offsets mapped.
- Write path: AW and W accepted independently into holding registers. s_awready = no AW held and no B pending; s_wready = no W held and no B pending.
- Read path: s_arready = !s_rvalid. Read and write paths fully independent.

## Timing
- Reset values: all ready/valid outputs 0 during reset, s_awready/s_wready/s_arready 1 from first cycle after release; bresp/rresp 0; s_rdata 0; tmr_start/tmr_stop 0; tmr_load_val 0; IE 0; PEND 0; irq 0.
- Write: edge at which second of AW/W is held (or both same edge) = commit edge N. Register updated and s_bvalid=1 after edge N+1; tmr_start/tmr_stop high for exactly cycle after N+1, irq reflects new IE one cycle later.
- s_bvalid held until s_bready sampled high; next AW/W not accepted before that edge.
- Read: AR handshake at edge N -> s_rvalid=1, s_rdata valid after N+1, COUNT value = tmr_count sampled at edge N. Held stable until s_rready.
- tmr_irq rise at edge N -> PEND=1 after N+1, irq=1 after N+2 (IE=1).
- Reset mid-transaction: pending B/R responses and held AW/W dropped, no pulses emitted.

## Structure
- Shared package timer_pkg: register offsets (CTRL/LOAD/COUNT/STATUS), CTRL/STATUS bit indices, AXI resp encodings.
- Single module, no sub-module; timer top level instantiates this block and the core.

## Test plan
- Write LOAD 0xDEAD_BEEF, wstrb 0xF, AW and W same cycle -> bresp OKAY, tmr_load_val=0xDEADBEEF, readback 0xDEADBEEF.
- W three cycles before AW, wstrb 0x2 data 0x0000_5A00 to LOAD=0 -> commit only after AW; LOAD=0x0000_5A00; bvalid held 4 cycles under bready=0.
- Write CTRL 0x5 -> tmr_start single-cycle pulse, IE=1, CTRL reads 0x4; write 0x3 -> start and stop pulse same cycle.
- tmr_irq rises with IE=1 -> PEND=1, irq=1 two cycles later; write STATUS 0x1 -> PEND=0, irq=0; W1C coincident with new rising edge -> PEND stays 1.
- tmr_count ramping, read COUNT with rready low 3 cycles -> rdata equals count at AR handshake, stable while waiting.
- rstn asserted with bvalid and rvalid pending -> both drop immediately, all registers reset, next transaction completes normally.
